// File: rtl/mdc_stream_join.sv
// mdc_stream_join: NUM_IN independent circular-buffer FIFOs feeding a join
// that emits one concatenated token only when every channel holds data.
// Optional output holding register enabled by defining MDC_STREAM_JOIN_OUTREG_EN.
module mdc_stream_join #(
    parameter int NUM_IN = 2,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [NUM_IN*DATA_W-1:0]              in_data,
    input  logic [NUM_IN-1:0]                     in_wr,
    output logic [NUM_IN-1:0]                     in_full,
    output logic [NUM_IN*($clog2(DEPTH)+1)-1:0]   in_level,
    output logic [NUM_IN-1:0]                     overflow,
    output logic [NUM_IN*DATA_W-1:0]              out_data,
    output logic                                  out_wr,
    input  logic                                  out_full,
    output logic [31:0]                           fire_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [NUM_IN-1:0]        wr_ok;
    logic [NUM_IN-1:0]        not_empty;
    logic [NUM_IN*DATA_W-1:0] heads;
    logic                     all_avail;
    logic                     pop;
    logic                     accept;

    assign all_avail = &not_empty;

    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_ch
        logic [DATA_W-1:0] mem [DEPTH];
        logic [PTR_W-1:0]  wp;
        logic [PTR_W-1:0]  rp;
        logic [CNT_W-1:0]  cnt;
        logic              ovf;

        // Full is taken from registered occupancy, so a same-cycle pop
        // never frees room for a write.
        assign in_full[gi]   = (cnt == CNT_W'(DEPTH));
        assign not_empty[gi] = (cnt != '0);
        assign wr_ok[gi]     = in_wr[gi] && !in_full[gi];
        assign overflow[gi]  = ovf;
        assign heads[gi*DATA_W +: DATA_W]   = mem[rp];
        assign in_level[gi*CNT_W +: CNT_W]  = cnt;

        // Storage array: write accepted words at the write pointer.
        always_ff @(posedge clock) begin
            if (wr_ok[gi]) begin
                mem[wp] <= in_data[gi*DATA_W +: DATA_W];
            end
        end

        // Pointers, occupancy and sticky overflow flag.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                wp  <= '0;
                rp  <= '0;
                cnt <= '0;
                ovf <= 1'b0;
            end else begin
                if (wr_ok[gi]) begin
                    wp <= wp + PTR_W'(1);
                end
                if (pop) begin
                    rp <= rp + PTR_W'(1);
                end
                case ({wr_ok[gi], pop})
                    2'b10:   cnt <= cnt + CNT_W'(1);
                    2'b01:   cnt <= cnt - CNT_W'(1);
                    default: cnt <= cnt;
                endcase
                if (in_wr[gi] && in_full[gi]) begin
                    ovf <= 1'b1;
                end
            end
        end
    end

`ifdef MDC_STREAM_JOIN_OUTREG_EN
    logic [NUM_IN*DATA_W-1:0] ob_data;
    logic                     ob_valid;

    // Loading the holding register is what pops every channel.
    assign pop      = all_avail && (!ob_valid || !out_full);
    assign out_wr   = ob_valid;
    assign out_data = ob_data;

    // One-entry output register: hold until downstream accepts.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ob_data  <= '0;
            ob_valid <= 1'b0;
        end else if (pop) begin
            ob_data  <= heads;
            ob_valid <= 1'b1;
        end else if (ob_valid && !out_full) begin
            ob_valid <= 1'b0;
        end
    end
`else
    // Heads are masked while no token is present so idle output reads zero.
    assign out_wr   = all_avail;
    assign out_data = all_avail ? heads : '0;
    assign pop      = all_avail && !out_full;
`endif

    assign accept = out_wr && !out_full;

    // Count tokens handed downstream; wraps naturally at 2^32.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fire_count <= '0;
        end else if (accept) begin
            fire_count <= fire_count + 32'd1;
        end
    end

endmodule
